pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline.
- Drives write-enable and flush controls for the PC, the IF/ID register and the ID/EX register.
- Resolves load-use hazards, taken-branch redirects, instruction-fetch wait and data-memory wait into one consistent per-cycle control set.
- Sits beside the datapath; consumes ID/EX hazard fields and memory ready/busy signals.

Parameters:
- REG_ADDR_WIDTH, 5, register-index width.
- FLUSH_CYCLES, 2, cycles IF/ID is flushed after a redirect (1..15); covers the wrong-path fetch in flight.
- MAX_WAIT, 255, MEM_WAIT cycles before hang_err sets (1..65535).
- PERF_WIDTH, 32, width of performance counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_ADDR_WIDTH  source 1 of the instruction in ID.
- id_rs2  in  REG_ADDR_WIDTH  source 2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_ADDR_WIDTH  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_busy  in  1  MEM stage access not complete.
- pc_we  out  1  PC update enable.
- if_id_we  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads zero (NOP).
- id_ex_bubble  out  1  ID/EX loads NOP; ID holds.
- id_ex_flush  out  1  ID/EX loads NOP (wrong path).
- mem_stall  out  1  freeze EX/MEM and MEM/WB.
- state_o  out  2  current state (debug).
- hang_err  out  1  sticky MEM_WAIT timeout.
- stall_cnt, flush_cnt, wait_cnt  out  PERF_WIDTH each  performance counters.

Behaviour:
- States: RUN=0, FLUSH=1, MEM_WAIT=2, FETCH_WAIT=3.
- Registered: state, flush counter fcnt (4 b), saved return state, wait counter (16 b), hang_err.
- Outputs are Mealy, combinational from state and inputs.
- Zero added latency: controls apply in the same cycle as the causing input.
- While rst=0:
  - state=RUN, fcnt=0, wait counter=0, hang_err=0, counters=0.
  - pc_we=0, if_id_we=0, if_id_flush=1, id_ex_flush=1, id_ex_bubble=0, mem_stall=0.
- Per-cycle priority, highest first:
  - P1, dmem_busy=1:
    - mem_stall=1; pc_we=0, if_id_we=0; all flush and bubble outputs 0.
    - Entering from a non-MEM_WAIT state saves that state as the return state; next state is MEM_WAIT.
    - fcnt is frozen.
    - ex_branch_taken is ignored because EX is frozen; it is re-sampled after the wait.
  - P2, ex_branch_taken=1:
    - pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=1.
    - fcnt=FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else RUN.
    - A branch arriving while in FLUSH reloads fcnt.
  - P3, state FLUSH:
    - if_id_flush=1, pc_we=imem_ready, id_ex_bubble=0.
    - fcnt decrements; when fcnt=1 on entry to the cycle, next state is RUN.
  - P4, load-use: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)):
    - pc_we=0, if_id_we=0, id_ex_bubble=1; next state RUN.
  - P5, imem_ready=0:
    - pc_we=0, if_id_we=1, if_id_flush=1; next state FETCH_WAIT.
    - FETCH_WAIT returns to RUN on the first cycle with imem_ready=1.
  - P6, otherwise: pc_we=1, if_id_we=1; all others 0; next state RUN.
- MEM_WAIT exit, first cycle with dmem_busy=0: evaluate P2..P6 using the saved return state.
- Wait counter:
  - Increments each MEM_WAIT cycle, saturating; cleared on exit.
  - Reaching MAX_WAIT sets hang_err.
  - hang_err clears only on reset.
- Invariants:
  - id_ex_bubble and id_ex_flush are never both 1.
  - if_id_flush=1 implies the IF/ID register writes a NOP regardless of if_id_we.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments on P4 cycles.
  - flush_cnt increments on P2 cycles.
  - wait_cnt increments on P1 cycles.
  - All counters saturate at all-ones and clear on reset.
- Undefined: counter registers are not built; the three ports are tied to 0; the port list is unchanged.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (2 b) with encodings above;
  - REG_ADDR_WIDTH default;
  - the NOP instruction constant (32'h00000013) used by pipeline registers on flush.
- Sub-module load_use_detect: purely combinational P4 compare producing one hazard bit; reused by any future forwarding unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> that cycle pc_we=0, if_id_we=0, id_ex_bubble=1; next cycle with ex_mem_read=0 -> all enables 1. Repeat with ex_rd=0 -> no stall.
- Branch redirect, FLUSH_CYCLES=2: ex_branch_taken=1 -> pc_we=1, if_id_flush=1, id_ex_flush=1, state->FLUSH; next cycle if_id_flush=1; following cycle state=RUN.
- Branch during dmem_busy: dmem_busy=1 for 3 cycles with ex_branch_taken=1 held -> mem_stall=1, no flush for 3 cycles; 4th cycle -> redirect controls asserted.
- Priority: load-use and ex_branch_taken in the same cycle -> branch wins (id_ex_flush=1, id_ex_bubble=0).
- Timeout, MAX_WAIT=4: dmem_busy=1 for 6 cycles -> hang_err=1 from the 4th wait cycle; stays 1 after dmem_busy=0 until rst pulses low.
- Reset mid-FLUSH: drop rst during FLUSH with fcnt=1 -> outputs go immediately to reset values; after release, state=RUN, no residual flush. With PIPE_HAZARD_CTRL_PERF_EN, flush_cnt reads 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FETCH_WAIT = 2'd3
  } state_e;

  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;

  // addi x0,x0,0 -- loaded by pipeline registers when flushed
  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use hazard compare: a load in EX whose destination is read by ID.
module load_use_detect #(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] i_id_rs1,
  input  logic [AW-1:0] i_id_rs2,
  input  logic          i_id_uses_rs1,
  input  logic          i_id_uses_rs2,
  input  logic [AW-1:0] i_ex_rd,
  input  logic          i_ex_mem_read,
  output logic          o_hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hazard  = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Optional performance counters enabled by PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned FLUSH_CYCLES   = 2,
  parameter int unsigned MAX_WAIT       = 255,
  parameter int unsigned PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      imem_ready,
  input  logic                      dmem_busy,
  output logic                      pc_we,
  output logic                      if_id_we,
  output logic                      if_id_flush,
  output logic                      id_ex_bubble,
  output logic                      id_ex_flush,
  output logic                      mem_stall,
  output logic [1:0]                state_o,
  output logic                      hang_err,
  output logic [PERF_WIDTH-1:0]     stall_cnt,
  output logic [PERF_WIDTH-1:0]     flush_cnt,
  output logic [PERF_WIDTH-1:0]     wait_cnt
);

  localparam logic [3:0]  FCNT_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WAIT_LIM  = 16'(MAX_WAIT);

  state_e      r_state, w_state_nxt;
  state_e      r_ret, w_ret_nxt;
  state_e      w_eff;
  logic [3:0]  r_fcnt, w_fcnt_nxt;
  logic [15:0] r_wcnt, w_wcnt_nxt;
  logic        r_hang, w_hang_nxt;
  logic        w_load_use;

  load_use_detect #(.AW(REG_ADDR_WIDTH)) u_load_use (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_hazard      (w_load_use)
  );

  // Leaving MEM_WAIT resumes decisions as if still in the interrupted state.
  assign w_eff = (r_state == ST_MEM_WAIT) ? r_ret : r_state;

  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_flush  = 1'b0;
    mem_stall    = 1'b0;
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret;
    w_fcnt_nxt   = r_fcnt;
    w_wcnt_nxt   = '0;
    w_hang_nxt   = r_hang;

    if (dmem_busy) begin
      mem_stall   = 1'b1;
      w_state_nxt = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) w_ret_nxt = r_state;
      // The entry cycle counts as the first wait cycle.
      w_wcnt_nxt  = (r_wcnt == '1) ? r_wcnt : r_wcnt + 16'd1;
      if (w_wcnt_nxt >= WAIT_LIM) w_hang_nxt = 1'b1;
    end else if (ex_branch_taken) begin
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_fcnt_nxt  = FCNT_LOAD;
      w_state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (w_eff == ST_FLUSH) begin
      pc_we       = imem_ready;
      if_id_we    = 1'b1;
      if_id_flush = 1'b1;
      w_fcnt_nxt  = (r_fcnt == '0) ? r_fcnt : r_fcnt - 4'd1;
      w_state_nxt = (r_fcnt <= 4'd1) ? ST_RUN : ST_FLUSH;
    end else if (w_load_use) begin
      id_ex_bubble = 1'b1;
      w_state_nxt  = ST_RUN;
    end else if (!imem_ready) begin
      if_id_we    = 1'b1;
      if_id_flush = 1'b1;
      w_state_nxt = ST_FETCH_WAIT;
    end else begin
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      w_state_nxt = ST_RUN;
    end

    if (!rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b0;
      id_ex_flush  = 1'b1;
      mem_stall    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_ret   <= ST_RUN;
      r_fcnt  <= '0;
      r_wcnt  <= '0;
      r_hang  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_hang  <= w_hang_nxt;
    end
  end

  assign state_o  = r_state;
  assign hang_err = r_hang;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam logic [PERF_WIDTH-1:0] PERF_ONE = PERF_WIDTH'(1);

  logic                  w_p2, w_p4;
  logic [PERF_WIDTH-1:0] r_stall_cnt, r_flush_cnt, r_wait_cnt;

  assign w_p2 = !dmem_busy && ex_branch_taken;
  assign w_p4 = !dmem_busy && !ex_branch_taken && (w_eff != ST_FLUSH) && w_load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_p4 && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + PERF_ONE;
      if (w_p2 && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + PERF_ONE;
      if (dmem_busy && (r_wait_cnt != '1)) r_wait_cnt <= r_wait_cnt + PERF_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign wait_cnt  = r_wait_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with FLUSH_CYCLES=2, MAX_WAIT=4.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic        imem_ready, dmem_busy;
  logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, id_ex_flush, mem_stall;
  logic [1:0]  state_o;
  logic        hang_err;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH (5),
    .FLUSH_CYCLES   (2),
    .MAX_WAIT       (4),
    .PERF_WIDTH     (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_busy       (dmem_busy),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .id_ex_flush     (id_ex_flush),
    .mem_stall       (mem_stall),
    .state_o         (state_o),
    .hang_err        (hang_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .wait_cnt        (wait_cnt)
  );

  always #5 clk = ~clk;

  // {pc_we, if_id_we, if_id_flush, id_ex_bubble, id_ex_flush, mem_stall}
  localparam logic [5:0] C_RST  = 6'b001010;
  localparam logic [5:0] C_RUN  = 6'b110000;
  localparam logic [5:0] C_LU   = 6'b000100;
  localparam logic [5:0] C_BR   = 6'b111010;
  localparam logic [5:0] C_FL   = 6'b111000;
  localparam logic [5:0] C_FLNR = 6'b011000;
  localparam logic [5:0] C_FW   = 6'b011000;
  localparam logic [5:0] C_MS   = 6'b000001;

  typedef struct {
    int          idx;
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic        hang;
    bit          chk_cnt;
    logic [31:0] sc, fc, wc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec      = 0;
  int   m_sc = 0, m_fc = 0, m_wc = 0;

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic ir, input logic busy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
    imem_ready = ir; dmem_busy = busy;
  endtask

  task automatic idle();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // cls: 1 = memory wait, 2 = redirect, 4 = load-use, 0 = other
  task automatic v(input logic [5:0] ctl, input logic [1:0] st, input logic hang,
                   input int cls, input bit chk);
    exp_t e;
    if (!rst) begin m_sc = 0; m_fc = 0; m_wc = 0; end
    e.idx = vec; e.ctl = ctl; e.st = st; e.hang = hang; e.chk_cnt = chk;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    e.sc = m_sc; e.fc = m_fc; e.wc = m_wc;
`else
    e.sc = 0; e.fc = 0; e.wc = 0;
`endif
    q.push_back(e);
    vec++;
    if (rst) begin
      if (cls == 1) m_wc++;
      if (cls == 2) m_fc++;
      if (cls == 4) m_sc++;
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [5:0]  act;
    if (q.size() != 0) begin
      e   = q.pop_front();
      act = {pc_we, if_id_we, if_id_flush, id_ex_bubble, id_ex_flush, mem_stall};
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL v%0d ctl got=%b exp=%b", e.idx, act, e.ctl);
      end
      checks++;
      if (state_o !== e.st) begin
        failures++;
        $display("FAIL v%0d state got=%0d exp=%0d", e.idx, state_o, e.st);
      end
      checks++;
      if (hang_err !== e.hang) begin
        failures++;
        $display("FAIL v%0d hang_err got=%b exp=%b", e.idx, hang_err, e.hang);
      end
      if (e.chk_cnt) begin
        checks += 3;
        if (stall_cnt !== e.sc) begin
          failures++;
          $display("FAIL v%0d stall_cnt got=%0d exp=%0d", e.idx, stall_cnt, e.sc);
        end
        if (flush_cnt !== e.fc) begin
          failures++;
          $display("FAIL v%0d flush_cnt got=%0d exp=%0d", e.idx, flush_cnt, e.fc);
        end
        if (wait_cnt !== e.wc) begin
          failures++;
          $display("FAIL v%0d wait_cnt got=%0d exp=%0d", e.idx, wait_cnt, e.wc);
        end
      end
    end
  end

  initial begin
    idle();
    @(posedge clk); #1;
    // reset values
    v(C_RST, ST_RUN, 1'b0, 0, 1'b1);
    rst = 1'b1;
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // load-use via rs1, release, then ex_rd=0 never stalls
    set_in(5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    v(C_LU, ST_RUN, 1'b0, 4, 1'b0);
    ex_mem_read = 1'b0;
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    set_in(5'd0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // load-use via rs2; same regs but unused operands do not stall
    set_in(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    v(C_LU, ST_RUN, 1'b0, 4, 1'b0);
    set_in(5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // branch redirect -> one FLUSH cycle -> RUN
    idle(); ex_branch_taken = 1'b1;
    v(C_BR, ST_RUN, 1'b0, 2, 1'b0);
    idle();
    v(C_FL, ST_FLUSH, 1'b0, 0, 1'b0);
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // FLUSH outranks load-use and fetch wait; pc_we follows imem_ready
    ex_branch_taken = 1'b1;
    v(C_BR, ST_RUN, 1'b0, 2, 1'b0);
    set_in(5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    v(C_FLNR, ST_FLUSH, 1'b0, 0, 1'b0);
    idle();
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // branch beats load-use in the same cycle
    set_in(5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    v(C_BR, ST_RUN, 1'b0, 2, 1'b0);
    idle();
    v(C_FL, ST_FLUSH, 1'b0, 0, 1'b0);
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // fetch wait
    imem_ready = 1'b0;
    v(C_FW, ST_RUN, 1'b0, 0, 1'b0);
    v(C_FW, ST_FETCH_WAIT, 1'b0, 0, 1'b0);
    imem_ready = 1'b1;
    v(C_RUN, ST_FETCH_WAIT, 1'b0, 0, 1'b0);
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // branch held through 3 busy cycles is acted on afterwards
    ex_branch_taken = 1'b1; dmem_busy = 1'b1;
    v(C_MS, ST_RUN, 1'b0, 1, 1'b0);
    v(C_MS, ST_MEM_WAIT, 1'b0, 1, 1'b0);
    v(C_MS, ST_MEM_WAIT, 1'b0, 1, 1'b0);
    dmem_busy = 1'b0;
    v(C_BR, ST_MEM_WAIT, 1'b0, 2, 1'b0);
    idle();
    v(C_FL, ST_FLUSH, 1'b0, 0, 1'b0);
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // busy inside FLUSH freezes it; flush resumes on exit
    ex_branch_taken = 1'b1;
    v(C_BR, ST_RUN, 1'b0, 2, 1'b0);
    idle(); dmem_busy = 1'b1;
    v(C_MS, ST_FLUSH, 1'b0, 1, 1'b0);
    dmem_busy = 1'b0;
    v(C_FL, ST_MEM_WAIT, 1'b0, 0, 1'b0);
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // timeout: hang_err from the 4th MEM_WAIT cycle, sticky
    dmem_busy = 1'b1;
    v(C_MS, ST_RUN, 1'b0, 1, 1'b0);
    v(C_MS, ST_MEM_WAIT, 1'b0, 1, 1'b0);
    v(C_MS, ST_MEM_WAIT, 1'b0, 1, 1'b0);
    v(C_MS, ST_MEM_WAIT, 1'b0, 1, 1'b0);
    v(C_MS, ST_MEM_WAIT, 1'b1, 1, 1'b0);
    v(C_MS, ST_MEM_WAIT, 1'b1, 1, 1'b0);
    dmem_busy = 1'b0;
    v(C_RUN, ST_MEM_WAIT, 1'b1, 0, 1'b0);
    v(C_RUN, ST_RUN, 1'b1, 0, 1'b0);
    // reset during FLUSH with fcnt=1
    ex_branch_taken = 1'b1;
    v(C_BR, ST_RUN, 1'b1, 2, 1'b0);
    idle(); rst = 1'b0;
    v(C_RST, ST_RUN, 1'b0, 0, 1'b1);
    rst = 1'b1;
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b0);
    // counter activity after reset
    set_in(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    v(C_LU, ST_RUN, 1'b0, 4, 1'b0);
    idle(); ex_branch_taken = 1'b1;
    v(C_BR, ST_RUN, 1'b0, 2, 1'b0);
    idle();
    v(C_FL, ST_FLUSH, 1'b0, 0, 1'b0);
    dmem_busy = 1'b1;
    v(C_MS, ST_RUN, 1'b0, 1, 1'b0);
    v(C_MS, ST_MEM_WAIT, 1'b0, 1, 1'b0);
    dmem_busy = 1'b0;
    v(C_RUN, ST_MEM_WAIT, 1'b0, 0, 1'b1);
    v(C_RUN, ST_RUN, 1'b0, 0, 1'b1);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
